k2_fetch_unit: RTL and testbench



---
 rtl/k2_pkg.sv | 27 ++
 rtl/k2_instr_mem.sv | 36 +++
 rtl/k2_fetch_unit.sv | 134 +++++++++++++
 tb/tb_k2_fetch_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/k2_pkg.sv
// rtl/k2_pkg.sv - shared types and instruction field positions for the K2 fetch unit
package k2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

    // Bit positions inside an 8-bit K2 instruction word
    localparam int J_BIT   = 7;
    localparam int C_BIT   = 6;
    localparam int D_MSB   = 5;
    localparam int D_LSB   = 4;
    localparam int S_BIT   = 3;
    localparam int IMM_MSB = 2;

    typedef struct packed {
        logic       j;
        logic       c;
        logic [1:0] d;
        logic       s_reg;
        logic [2:0] imm;
    } k2_instr_t;

endpackage

// File: rtl/k2_instr_mem.sv
// rtl/k2_instr_mem.sv - instruction RAM, one synchronous write port and one synchronous read port
//
// Ports:
//   clk              rising-edge clock
//   wr_en/wr_addr/wr_data   write port (loader side)
//   rd_en/rd_addr    read request; rd_data updates on the next edge when rd_en=1
//   rd_data          registered read data, holds while rd_en=0
// Contents and the read register are deliberately not reset.
module k2_instr_mem #(
    parameter int ADDR_BITS  = 4,
    parameter int INSTR_BITS = 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [INSTR_BITS-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_BITS-1:0]  rd_addr,
    output logic [INSTR_BITS-1:0] rd_data
);

    logic [INSTR_BITS-1:0] mem_q [2**ADDR_BITS];
    logic [INSTR_BITS-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/k2_fetch_unit.sv
// rtl/k2_fetch_unit.sv - K2 instruction fetch stage: loader, PC sequencing and field split
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   load_valid/load_ready    loader handshake; load_addr/load_data word, load_done ends the load
//   start, halt_req, stall   execution control
//   jcf                      jump taken for the presented instruction
//   pc, instr, instr_valid   presented instruction and its address
//   j, c, d, s_reg, imm      decoded fields of instr
//   state                    FSM state (debug)
module k2_fetch_unit
    import k2_pkg::*;
#(
    parameter int ADDR_BITS  = 4,
    parameter int INSTR_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [ADDR_BITS-1:0]  load_addr,
    input  logic [INSTR_BITS-1:0] load_data,
    input  logic                  load_done,
    input  logic                  start,
    input  logic                  halt_req,
    input  logic                  stall,
    input  logic                  jcf,
    output logic [ADDR_BITS-1:0]  pc,
    output logic [INSTR_BITS-1:0] instr,
    output logic                  instr_valid,
    output logic                  j,
    output logic                  c,
    output logic [1:0]            d,
    output logic                  s_reg,
    output logic [2:0]            imm,
    output logic [1:0]            state
);

    fetch_state_t          state_q, state_d;
    logic [ADDR_BITS-1:0]  pc_q, pc_d;
    logic                  rd_en;
    logic                  wr_en;
    logic                  rd_seen_q;
    logic [INSTR_BITS-1:0] rd_data;
    k2_instr_t             cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            rd_seen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (rd_en) begin
                rd_seen_q <= 1'b1;
            end
        end
    end

    // The RAM is read at the next PC, so the word lands on instr in the same
    // edge that pc_q takes that address; a jump therefore costs no bubble.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    state_d = LOAD;
                end else if (start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    rd_en   = 1'b1;
                end
            end
            LOAD: begin
                wr_en = load_valid;
                if (load_done) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_d = HALT;
                end else if (!stall) begin
                    rd_en = 1'b1;
                    pc_d  = jcf ? ADDR_BITS'(cur.imm) : pc_q + ADDR_BITS'(1);
                end
            end
            HALT: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    rd_en   = 1'b1;
                end else if (load_valid) begin
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write enable comes from the registered state, so an asserted rst
    // suppresses any write that was about to happen.
    k2_instr_mem #(
        .ADDR_BITS  (ADDR_BITS),
        .INSTR_BITS (INSTR_BITS)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_en   (rd_en),
        .rd_addr (pc_d),
        .rd_data (rd_data)
    );

    // The RAM read register has no reset; mask it until the first fetch
    // after reset so instr reads as zero.
    assign instr       = rd_seen_q ? rd_data : '0;
    assign cur         = k2_instr_t'(instr);
    assign pc          = pc_q;
    assign state       = state_q;
    assign load_ready  = (state_q == LOAD);
    assign instr_valid = (state_q == RUN);
    assign j           = instr[J_BIT];
    assign c           = instr[C_BIT];
    assign d           = instr[D_MSB:D_LSB];
    assign s_reg       = instr[S_BIT];
    assign imm         = instr[IMM_MSB:0];

endmodule

// File: tb/tb_k2_fetch_unit.sv
// tb/tb_k2_fetch_unit.sv - self-checking bench for k2_fetch_unit
module tb_k2_fetch_unit;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [3:0] load_addr = '0;
    logic [7:0] load_data = '0;
    logic       load_done = 1'b0;
    logic       start = 1'b0;
    logic       halt_req = 1'b0;
    logic       stall = 1'b0;
    logic       jcf = 1'b0;
    logic [3:0] pc;
    logic [7:0] instr;
    logic       instr_valid;
    logic       j, c, s_reg;
    logic [1:0] d;
    logic [2:0] imm;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    logic [7:0] prog [DEPTH];

    // reference model: spec-level view, instr is simply mem[pc]
    logic [7:0] m_mem [DEPTH];
    int         m_state = 0;
    int         m_pc = 0;
    logic [7:0] m_instr = '0;

    k2_fetch_unit #(.ADDR_BITS(4), .INSTR_BITS(8)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
        .start(start), .halt_req(halt_req), .stall(stall), .jcf(jcf),
        .pc(pc), .instr(instr), .instr_valid(instr_valid),
        .j(j), .c(c), .d(d), .s_reg(s_reg), .imm(imm), .state(state)
    );

    always #5 clk = ~clk;

    function automatic int next_addr(input int cur_pc, input logic [7:0] ins, input logic take);
        return take ? int'(ins[2:0]) : (cur_pc + 1) % DEPTH;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= 0;
            m_pc    <= 0;
            m_instr <= '0;
        end else begin
            case (m_state)
                0: if (load_valid) m_state <= 1;
                   else if (start) begin m_state <= 2; m_pc <= 0; m_instr <= m_mem[0]; end
                1: begin
                       if (load_valid) m_mem[load_addr] <= load_data;
                       if (load_done) m_state <= 0;
                   end
                2: if (halt_req) m_state <= 3;
                   else if (!stall) begin
                       m_pc    <= next_addr(m_pc, m_instr, jcf);
                       m_instr <= m_mem[next_addr(m_pc, m_instr, jcf)];
                   end
                default: if (start) begin m_state <= 2; m_pc <= 0; m_instr <= m_mem[0]; end
                         else if (load_valid) m_state <= 1;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            n_cmp++;
            if ({int'(state), int'(pc)} != {m_state, m_pc} ||
                instr_valid !== (m_state == 2) || load_ready !== (m_state == 1)) begin
                n_bad++;
                $display("FAIL ctl @%0t: state=%0d pc=%0d valid=%b ready=%b expected state=%0d pc=%0d",
                         $time, state, pc, instr_valid, load_ready, m_state, m_pc);
            end
            n_cmp++;
            if (instr !== m_instr || j !== m_instr[7] || c !== m_instr[6] ||
                d !== m_instr[5:4] || s_reg !== m_instr[3] || imm !== m_instr[2:0]) begin
                n_bad++;
                $display("FAIL instr @%0t: instr=%h j=%b c=%b d=%0d s=%b imm=%0d expected instr=%h",
                         $time, instr, j, c, d, s_reg, imm, m_instr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load_prog();
        load_valid = 1'b1;
        load_addr  = 4'd0;
        load_data  = prog[0];
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            load_addr = 4'(i);
            load_data = prog[i];
            load_done = (i == DEPTH - 1);
            tick();
        end
        load_valid = 1'b0;
        load_done  = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) prog[i] = 8'($urandom);
        prog[0] = 8'h01; prog[1] = 8'h12; prog[2] = 8'h23; prog[3] = 8'h34;

        tick(); tick();
        cmp_en = 1'b1;
        chk("reset pc", int'(pc), 0);
        chk("reset instr", int'(instr), 0);
        chk("reset valid", int'(instr_valid), 0);
        chk("reset ready", int'(load_ready), 0);
        chk("reset state", int'(state), 0);
        rst = 1'b0;

        // load and run 0..3
        load_prog();
        do_start();
        chk("run state", int'(state), 2);
        chk("run valid", int'(instr_valid), 1);
        chk("run pc0", int'(pc), 0);   chk("run i0", int'(instr), 'h01);
        tick(); chk("run pc1", int'(pc), 1); chk("run i1", int'(instr), 'h12);
        tick(); chk("run pc2", int'(pc), 2); chk("run i2", int'(instr), 'h23);
        tick(); chk("run pc3", int'(pc), 3); chk("run i3", int'(instr), 'h34);

        // wrap 14,15,0,1
        repeat (11) tick();
        chk("wrap pc14", int'(pc), 14);
        tick(); chk("wrap pc15", int'(pc), 15);
        tick(); chk("wrap pc0", int'(pc), 0);
        tick(); chk("wrap pc1", int'(pc), 1);

        // stall three cycles at pc 1
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall pc", int'(pc), 1);
            chk("stall instr", int'(instr), 'h12);
        end
        stall = 1'b0;
        tick(); chk("post-stall pc", int'(pc), 2);

        // halt at pc 2, resume at 0
        halt_req = 1'b1;
        tick(); halt_req = 1'b0;
        chk("halt state", int'(state), 3);
        chk("halt valid", int'(instr_valid), 0);
        chk("halt pc", int'(pc), 2);
        do_start();
        chk("resume pc", int'(pc), 0);
        chk("resume instr", int'(instr), 'h01);

        // reload from HALT with a jump at 2
        halt_req = 1'b1;
        tick(); halt_req = 1'b0;
        prog[2] = 8'h85; prog[5] = 8'h5A;
        load_prog();
        do_start();
        tick(); tick();
        chk("jmp instr", int'(instr), 'h85);
        chk("jmp j", int'(j), 1);
        chk("jmp imm", int'(imm), 5);
        jcf = 1'b1;
        tick();
        chk("jmp pc", int'(pc), 5);
        chk("jmp target", int'(instr), 'h5A);
        tick(); jcf = 1'b0;
        chk("jmp back pc", int'(pc), 2);
        tick(); chk("nojmp pc", int'(pc), 3);
        repeat (3) tick();
        chk("pre-rst pc", int'(pc), 6);

        // asynchronous reset mid-RUN
        #2 rst = 1'b1;
        #1;
        chk("arst pc", int'(pc), 0);
        chk("arst valid", int'(instr_valid), 0);
        chk("arst state", int'(state), 0);
        tick(); rst = 1'b0;
        do_start();
        chk("retain instr", int'(instr), 'h01);

        // halt beats stall and jcf
        halt_req = 1'b1; stall = 1'b1; jcf = 1'b1;
        tick();
        halt_req = 1'b0; stall = 1'b0; jcf = 1'b0;
        chk("prio state", int'(state), 3);
        chk("prio pc", int'(pc), 0);

        // load beats start in IDLE
        rst = 1'b1; tick(); rst = 1'b0;
        load_valid = 1'b1; start = 1'b1; load_addr = 4'd0; load_data = 8'h01;
        tick();
        start = 1'b0;
        chk("prio load", int'(state), 1);
        load_done = 1'b1;
        tick();
        load_valid = 1'b0; load_done = 1'b0;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 199) == 0);
            load_valid = ($urandom_range(0, 2) == 0);
            load_done  = ($urandom_range(0, 7) == 0);
            start      = ($urandom_range(0, 9) == 0);
            halt_req   = ($urandom_range(0, 19) == 0);
            stall      = ($urandom_range(0, 3) == 0);
            jcf        = ($urandom_range(0, 3) == 0);
            load_addr  = 4'($urandom);
            load_data  = 8'($urandom);
            tick();
        end
        rst = 1'b0;
        tick();
        cmp_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
